uart_rx: RTL and testbench

- UART receiver, 8N1 format, LSB first, fixed baud set by parameters.
- Oversamples `rx_pin` with the system clock and samples each bit at mid-period.
- Presents each byte with a valid/ready handshake.
- Sits under the MCU's memory-mapped UART RX GPIO wrapper: RXDATA reads `rx_data`, RXSTATUS reads `rx_data_valid`, and RXCTRL bit 0 drives `rx_data_ready`.

---
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first. rx_pin is synchronised, oversampled at
// CYCLE clocks per bit and sampled at mid-bit. Received bytes are handed
// out through a level valid / ready handshake.
module uart_rx #(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready
);

    localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int CNT_W = (CYCLE > 2) ? $clog2(CYCLE) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLE - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CYCLE / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        REC_BYTE,
        STOP,
        DATA
    } state_t;

    state_t            state_q, state_d;
    logic              rx_d0_q, rx_d0_d;
    logic              rx_d1_q, rx_d1_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_data_valid_q, rx_data_valid_d;
    logic              start_edge;

    // Falling edge seen between the two synchroniser stages marks a start bit.
    assign start_edge = rx_d1_q & ~rx_d0_q;

    // Next-state, counter, shift-register and output computation.
    always_comb begin
        state_d         = state_q;
        rx_d0_d         = rx_pin;
        rx_d1_d         = rx_d0_q;
        cycle_cnt_d     = cycle_cnt_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        rx_data_d       = rx_data_q;
        rx_data_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = START;
                end
            end
            START: begin
                if (cycle_cnt_q == CNT_MID && rx_d1_q) begin
                    state_d = IDLE;
                end else if (cycle_cnt_q == CNT_LAST) begin
                    state_d   = REC_BYTE;
                    bit_cnt_d = 3'd0;
                end
            end
            REC_BYTE: begin
                if (cycle_cnt_q == CNT_MID) begin
                    shift_d[bit_cnt_q] = rx_d1_q;
                end
                if (cycle_cnt_q == CNT_LAST) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cycle_cnt_q == CNT_MID) begin
                    state_d   = DATA;
                    rx_data_d = shift_q;
                end
            end
            DATA: begin
                if (rx_data_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cycle_cnt_d = '0;
        end else if (state_q == REC_BYTE && cycle_cnt_q == CNT_LAST) begin
            cycle_cnt_d = '0;
        end else if (state_q == START || state_q == REC_BYTE || state_q == STOP) begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
        end else begin
            cycle_cnt_d = '0;
        end

        rx_data_valid_d = (state_d == DATA);
    end

    // State and datapath registers; synchroniser flops reset to the idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            rx_d0_q         <= 1'b1;
            rx_d1_q         <= 1'b1;
            cycle_cnt_q     <= '0;
            bit_cnt_q       <= 3'd0;
            shift_q         <= 8'd0;
            rx_data_q       <= 8'd0;
            rx_data_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rx_d0_q         <= rx_d0_d;
            rx_d1_q         <= rx_d1_d;
            cycle_cnt_q     <= cycle_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            rx_data_q       <= rx_data_d;
            rx_data_valid_q <= rx_data_valid_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_data_valid = rx_data_valid_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 10 clocks per bit. Frames are built from
// the byte value bit by bit; each expected byte and its start time go into a
// queue that a negedge monitor drains whenever valid rises.
module tb_uart_rx;

    localparam int CLK_FRE   = 1;
    localparam int BAUD_RATE = 100000;
    localparam int CYCLE     = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int LAT       = 2 + 9 * CYCLE + CYCLE / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_pin = 1'b1;
    logic       rx_data_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_data_valid;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;

    exp_t exp_q[$];

    uart_rx #(
        .CLK_FRE  (CLK_FRE),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_pin       (rx_pin),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .rx_data_ready(rx_data_ready)
    );

    // Free-running clock and cycle counter used for latency measurement.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        tests++;
        if (actual < lo || actual > hi) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, required %0d..%0d (t=%0t)", name, actual, lo, hi, $time);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic driveBit(input logic v);
        rx_pin = v;
        waitCycles(CYCLE);
    endtask

    // Sends one 8N1 frame; entered and left one delay step after a posedge.
    task automatic applyStimulus(input logic [7:0] b, input bit expect_it);
        exp_t e;
        rx_pin = 1'b0;
        if (expect_it) begin
            e.data  = b;
            e.start = cyc;
            exp_q.push_back(e);
        end
        waitCycles(CYCLE);
        for (int i = 0; i < 8; i++) begin
            driveBit(((b >> i) & 8'd1) != 8'd0);
        end
        driveBit(1'b1);
    endtask

    // Scoreboard monitor: each rising valid must match the oldest expected byte.
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_valid && prev_ready) begin
                checkOutput("valid_pulse_width", {31'd0, rx_data_valid}, 32'd0);
            end
            if (rx_data_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                    checkRange("latency", cyc - e.start, LAT - 3, LAT + 3);
                end
            end
            prev_valid = rx_data_valid;
            prev_ready = rx_data_ready;
        end
    end

    int valid_seen;
    int waited;
    logic [7:0] rnd_byte;

    initial begin
        // Reset state
        #2;
        checkOutput("reset_rx_data", {24'd0, rx_data}, 32'd0);
        checkOutput("reset_valid", {31'd0, rx_data_valid}, 32'd0);
        @(posedge clk);
        waitCycles(3);
        rst_n = 1'b1;

        // Idle line: no activity for 500 clocks
        valid_seen = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (rx_data_valid) valid_seen++;
        end
        @(posedge clk);
        #1;
        checkOutput("idle_no_valid", valid_seen, 32'd0);
        checkOutput("idle_rx_data", {24'd0, rx_data}, 32'd0);

        // Single byte with ready held high
        rx_data_ready = 1'b1;
        applyStimulus(8'hA5, 1'b1);
        waitCycles(5);
        checkOutput("a5_held_data", {24'd0, rx_data}, 32'hA5);
        checkOutput("a5_valid_low", {31'd0, rx_data_valid}, 32'd0);

        // Unacknowledged byte, then an overrun frame that must be dropped
        rx_data_ready = 1'b0;
        applyStimulus(8'h3C, 1'b1);
        waitCycles(5);
        checkOutput("3c_valid_held", {31'd0, rx_data_valid}, 32'd1);
        checkOutput("3c_data", {24'd0, rx_data}, 32'h3C);
        applyStimulus(8'hFF, 1'b0);
        waitCycles(5);
        checkOutput("overrun_valid_held", {31'd0, rx_data_valid}, 32'd1);
        checkOutput("overrun_data_kept", {24'd0, rx_data}, 32'h3C);
        rx_data_ready = 1'b1;
        waitCycles(1);
        rx_data_ready = 1'b0;
        @(negedge clk);
        checkOutput("ack_valid_drop", {31'd0, rx_data_valid}, 32'd0);
        checkOutput("ack_data_kept", {24'd0, rx_data}, 32'h3C);
        @(posedge clk);
        #1;
        waitCycles(20);

        // Back-to-back frames with ready held high
        rx_data_ready = 1'b1;
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'h55, 1'b1);
        waitCycles(5);
        checkOutput("b2b_last_data", {24'd0, rx_data}, 32'h55);

        // Short low glitch must not start a frame
        rx_pin = 1'b0;
        waitCycles(3);
        rx_pin = 1'b1;
        valid_seen = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (rx_data_valid) valid_seen++;
        end
        @(posedge clk);
        #1;
        checkOutput("glitch_no_valid", valid_seen, 32'd0);
        applyStimulus(8'h81, 1'b1);
        waitCycles(5);
        checkOutput("after_glitch_data", {24'd0, rx_data}, 32'h81);

        // Reset after four data bits discards the partial byte
        rx_pin = 1'b0;
        waitCycles(CYCLE);
        for (int i = 0; i < 4; i++) begin
            driveBit(((8'hC3 >> i) & 8'd1) != 8'd0);
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_rx_data", {24'd0, rx_data}, 32'd0);
        checkOutput("midreset_valid", {31'd0, rx_data_valid}, 32'd0);
        rx_pin = 1'b1;
        @(posedge clk);
        waitCycles(3);
        rst_n = 1'b1;
        waitCycles(20);
        applyStimulus(8'h7E, 1'b1);
        waitCycles(5);
        checkOutput("post_reset_data", {24'd0, rx_data}, 32'h7E);

        // Randomised bytes with random idle gaps
        for (int i = 0; i < 8; i++) begin
            rnd_byte = 8'($urandom_range(0, 255));
            waitCycles($urandom_range(0, 15));
            applyStimulus(rnd_byte, 1'b1);
        end

        // Every expected byte must have been presented
        waited = 0;
        while (exp_q.size() != 0 && waited < 300) begin
            waitCycles(1);
            waited++;
        end
        checkOutput("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Guard against a hung simulation.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
